// File: rtl/apb_slave_model.sv
// ---------------------------------------------------------------------------
// apb_slave_model
// Behavioural-but-synthesizable APB slave with NUM_SEL independent channels.
// Each channel has DEPTH words of DATA_W storage. Every access can be
// stretched by WAIT_CYCLES wait states.
//
// Optional feature: define APB_SLV_ERR_EN to enable error responses. An
// errored transfer has out-of-range upper address bits or a non-one-hot
// Pselx at setup. Without the macro, Pslverr is tied low, upper address
// bits alias, and the lowest set Pselx bit wins.
//
// Handshake: a transfer is a setup cycle (Pselx!=0, Penable=0) followed by
// one or more access cycles (Penable=1). The transfer completes in the
// access cycle where Pready=1. The master must hold Pselx, Paddr, Pwrite and
// Pwdata stable from setup until that cycle.
//
// Ports:
//   clock     - sole clock, rising edge
//   Preset    - synchronous active-high reset (clears storage too)
//   Paddr     - byte address; word index = Paddr[log2(DEPTH)+1:2]
//   Pselx     - per-channel select
//   Penable   - access phase indicator
//   Pwrite    - 1 = write, 0 = read
//   Pwdata    - write data
//   Prdata    - read data, zero except on a completing read
//   Pready    - transfer completion
//   Pslverr   - transfer error, only ever high together with Pready
//   fsm_state - debug view of the FSM state (0 = IDLE, 1 = ACCESS)
// ---------------------------------------------------------------------------
module apb_slave_model #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_SEL     = 4,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic               clock,
   input  logic               Preset,
   input  logic [ADDR_W-1:0]  Paddr,
   input  logic [NUM_SEL-1:0] Pselx,
   input  logic               Penable,
   input  logic               Pwrite,
   input  logic [DATA_W-1:0]  Pwdata,
   output logic [DATA_W-1:0]  Prdata,
   output logic               Pready,
   output logic               Pslverr,
   output logic [0:0]         fsm_state
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CH_W  = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
   localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

   logic [0:0]       state;
   logic [3:0]       wcnt;
   logic [IDX_W-1:0] idx_q;
   logic [CH_W-1:0]  ch_q;
   logic             we_q;
   logic             err_q;
   logic [CH_W-1:0]  sel_ch;
   logic             setup_err;
   logic             any_sel;

   logic [DATA_W-1:0] mem [NUM_SEL][DEPTH];

   // Byte-lane bits are never used; upper bits are only used for error
   // detection when that feature is compiled in.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, Paddr[1:0], Paddr[ADDR_W-1:IDX_W+2]};

   assign any_sel   = |Pselx;
   assign fsm_state = state;

   // Priority encoder: scanning downward makes the lowest set bit win.
   always_comb begin
      sel_ch = '0;
      for (int i = NUM_SEL - 1; i >= 0; i--) begin
         if (Pselx[i]) sel_ch = CH_W'(i);
      end
   end

`ifdef APB_SLV_ERR_EN
   assign setup_err = (Paddr[ADDR_W-1:IDX_W+2] != '0) || !$onehot(Pselx);
`else
   assign setup_err = 1'b0;
`endif

   // Pready is additionally gated by Pselx. This keeps an aborted access
   // (select dropped while Penable is high) from ever signalling completion.
   assign Pready = (state == ACCESS) && Penable && any_sel && (wcnt == WAIT_MAX);

   always_comb begin
      Prdata  = '0;
      Pslverr = 1'b0;
      if (Pready) begin
         Pslverr = err_q;
         if (!we_q && !err_q) Prdata = mem[ch_q][idx_q];
      end
   end

   always_ff @(posedge clock) begin
      if (Preset) begin
         state <= IDLE;
         wcnt  <= '0;
         idx_q <= '0;
         ch_q  <= '0;
         we_q  <= 1'b0;
         err_q <= 1'b0;
         for (int c = 0; c < NUM_SEL; c++) begin
            for (int w = 0; w < DEPTH; w++) begin
               mem[c][w] <= '0;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (any_sel && !Penable) begin
                  state <= ACCESS;
                  wcnt  <= '0;
                  idx_q <= Paddr[IDX_W+1:2];
                  ch_q  <= sel_ch;
                  we_q  <= Pwrite;
                  err_q <= setup_err;
               end
            end
            ACCESS: begin
               if (!any_sel) begin
                  // Abort: the select was dropped before completion.
                  state <= IDLE;
               end else if (Pready) begin
                  if (we_q && !err_q) mem[ch_q][idx_q] <= Pwdata;
                  // Pready implies Penable=1, so no new setup can be seen on
                  // this edge. A back-to-back setup arrives on the very next
                  // edge and is picked up in IDLE without a bubble.
                  state <= IDLE;
               end else if (Penable && (wcnt != WAIT_MAX)) begin
                  // Wait states only elapse while the master is in the
                  // access phase; Penable=0 freezes the count.
                  wcnt <= wcnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_slave_model.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_model
// Directed bench for apb_slave_model. It instantiates three copies that differ
// only in WAIT_CYCLES (0, 3, 2). Each copy has its own bus signals, so the
// wait-state cases run side by side. Expected values for the error-response
// feature follow APB_SLV_ERR_EN as seen by this file.
// ---------------------------------------------------------------------------
module tb_apb_slave_model;

`ifdef APB_SLV_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        preset  [3];
   logic [31:0] paddr   [3];
   logic [3:0]  pselx   [3];
   logic        penable [3];
   logic        pwrite  [3];
   logic [31:0] pwdata  [3];
   logic [31:0] prdata  [3];
   logic        pready  [3];
   logic        pslverr [3];
   logic [0:0]  fsm_st  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_slave_model #(
         .ADDR_W(32), .DATA_W(32), .NUM_SEL(4), .DEPTH(16),
         .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
      ) dut (
         .clock    (clk),
         .Preset   (preset[g]),
         .Paddr    (paddr[g]),
         .Pselx    (pselx[g]),
         .Penable  (penable[g]),
         .Pwrite   (pwrite[g]),
         .Pwdata   (pwdata[g]),
         .Prdata   (prdata[g]),
         .Pready   (pready[g]),
         .Pslverr  (pslverr[g]),
         .fsm_state(fsm_st[g])
      );
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // ---------------- driver tasks ----------------
   // One full transfer: setup, optional stall cycles with Penable low,
   // then access until Pready. It returns in the completing cycle, so the
   // next call starts back-to-back without an idle cycle.
   task automatic xfer(input int d, input logic [31:0] addr, input logic [3:0] sel,
                       input logic wr, input logic [31:0] wdata, input int stall,
                       output logic [31:0] rdata, output logic err, output int waits);
      @(negedge clk);
      paddr[d] = addr; pselx[d] = sel; penable[d] = 1'b0;
      pwrite[d] = wr;  pwdata[d] = wdata;
      repeat (stall) @(negedge clk);
      @(negedge clk);
      penable[d] = 1'b1;
      waits = 0;
      #1;
      while (!pready[d] && waits < 20) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (waits >= 20) check("ready_timeout", 32'(pready[d]), 32'd1);
      rdata = prdata[d];
      err   = pslverr[d];
   endtask

   task automatic bus_idle(input int d);
      @(negedge clk);
      pselx[d] = '0; penable[d] = 1'b0; pwrite[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [31:0] rd;
   logic        er;
   int          wt;

   initial begin
      for (int d = 0; d < 3; d++) begin
         preset[d] = 1'b1; paddr[d] = '0; pselx[d] = '0; penable[d] = 1'b0;
         pwrite[d] = 1'b0; pwdata[d] = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("rst_pready", 32'(pready[d]), 32'd0);
         check("rst_prdata", prdata[d], 32'd0);
         check("rst_pslverr", 32'(pslverr[d]), 32'd0);
         check("rst_state", 32'(fsm_st[d]), 32'd0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) preset[d] = 1'b0;

      // Zero-wait write then read on channel 2.
      xfer(0, 32'h8, 4'b0100, 1'b1, 32'hDEADBEEF, 0, rd, er, wt);
      check("w0_wr_waits", 32'(wt), 32'd0);
      check("w0_wr_prdata", rd, 32'd0);
      xfer(0, 32'h8, 4'b0100, 1'b0, 32'h0, 0, rd, er, wt);
      check("w0_rd_waits", 32'(wt), 32'd0);
      check("w0_rd_data", rd, 32'hDEADBEEF);
      check("w0_rd_err", 32'(er), 32'd0);
      xfer(0, 32'h8, 4'b0001, 1'b0, 32'h0, 0, rd, er, wt);
      check("ch_isolation", rd, 32'd0);
      bus_idle(0);

      // Three wait states; the stalled write must still see all three.
      xfer(1, 32'h4, 4'b0001, 1'b0, 32'h0, 0, rd, er, wt);
      check("w3_rd_waits", 32'(wt), 32'd3);
      check("w3_rd_data", rd, 32'd0);
      xfer(1, 32'h10, 4'b1000, 1'b1, 32'hA5A55A5A, 2, rd, er, wt);
      check("w3_stall_waits", 32'(wt), 32'd3);
      xfer(1, 32'h10, 4'b1000, 1'b0, 32'h0, 0, rd, er, wt);
      check("w3_rd2_waits", 32'(wt), 32'd3);
      check("w3_rd2_data", rd, 32'hA5A55A5A);
      bus_idle(1);

      // Back-to-back writes then reads, channel 1, first and last word.
      exp_q.push_back(32'h11112222);
      exp_q.push_back(32'h33334444);
      xfer(0, 32'h00, 4'b0010, 1'b1, 32'h11112222, 0, rd, er, wt);
      xfer(0, 32'h3C, 4'b0010, 1'b1, 32'h33334444, 0, rd, er, wt);
      xfer(0, 32'h00, 4'b0010, 1'b0, 32'h0, 0, rd, er, wt);
      check("b2b_rd0", rd, exp_q.pop_front());
      xfer(0, 32'h3C, 4'b0010, 1'b0, 32'h0, 0, rd, er, wt);
      check("b2b_rd1", rd, exp_q.pop_front());
      bus_idle(0);

      // Reset in the middle of a two-wait-state write.
      xfer(2, 32'h00, 4'b0001, 1'b1, 32'h0BADF00D, 0, rd, er, wt);
      check("w2_wr_waits", 32'(wt), 32'd2);
      @(negedge clk);
      paddr[2] = 32'hC; pselx[2] = 4'b0001; penable[2] = 1'b0;
      pwrite[2] = 1'b1; pwdata[2] = 32'h12345678;
      @(negedge clk);
      penable[2] = 1'b1;
      #1;
      check("mid_rst_pready_a", 32'(pready[2]), 32'd0);
      @(negedge clk);
      preset[2] = 1'b1;
      #1;
      check("mid_rst_pready_b", 32'(pready[2]), 32'd0);
      @(negedge clk);
      preset[2] = 1'b0; pselx[2] = '0; penable[2] = 1'b0;
      #1;
      check("post_rst_pready", 32'(pready[2]), 32'd0);
      check("post_rst_state", 32'(fsm_st[2]), 32'd0);
      xfer(2, 32'hC, 4'b0001, 1'b0, 32'h0, 0, rd, er, wt);
      check("post_rst_rd_c", rd, 32'd0);
      xfer(2, 32'h0, 4'b0001, 1'b0, 32'h0, 0, rd, er, wt);
      check("post_rst_rd_0", rd, 32'd0);
      bus_idle(2);

      // Abort: select dropped during the access phase.
      @(negedge clk);
      paddr[0] = 32'h14; pselx[0] = 4'b0001; penable[0] = 1'b0;
      pwrite[0] = 1'b1; pwdata[0] = 32'h000055AA;
      @(negedge clk);
      penable[0] = 1'b1; pselx[0] = '0;
      #1;
      check("abort_pready", 32'(pready[0]), 32'd0);
      bus_idle(0);
      #1;
      check("abort_state", 32'(fsm_st[0]), 32'd0);
      xfer(0, 32'h14, 4'b0001, 1'b0, 32'h0, 0, rd, er, wt);
      check("abort_no_write", rd, 32'd0);

      // Out-of-range address: error or alias to index 0.
      xfer(0, 32'h000, 4'b1000, 1'b1, 32'h600DCAFE, 0, rd, er, wt);
      check("oor_base_err", 32'(er), 32'd0);
      xfer(0, 32'h100, 4'b1000, 1'b1, 32'hBAD00BAD, 0, rd, er, wt);
      check("oor_wr_err", 32'(er), 32'(ERR_EN));
      xfer(0, 32'h100, 4'b1000, 1'b0, 32'h0, 0, rd, er, wt);
      check("oor_rd_err", 32'(er), 32'(ERR_EN));
      check("oor_rd_data", rd, ERR_EN ? 32'h0 : 32'hBAD00BAD);
      xfer(0, 32'h000, 4'b1000, 1'b0, 32'h0, 0, rd, er, wt);
      check("oor_alias_rd", rd, ERR_EN ? 32'h600DCAFE : 32'hBAD00BAD);

      // Non-one-hot select: error or lowest-index channel.
      xfer(0, 32'h20, 4'b0010, 1'b1, 32'h11111111, 0, rd, er, wt);
      xfer(0, 32'h20, 4'b0110, 1'b1, 32'h22222222, 0, rd, er, wt);
      check("multi_sel_err", 32'(er), 32'(ERR_EN));
      xfer(0, 32'h20, 4'b0010, 1'b0, 32'h0, 0, rd, er, wt);
      check("multi_sel_ch1", rd, ERR_EN ? 32'h11111111 : 32'h22222222);
      xfer(0, 32'h20, 4'b0100, 1'b0, 32'h0, 0, rd, er, wt);
      check("multi_sel_ch2", rd, 32'h0);
      bus_idle(0);
      #1;
      check("idle_prdata", prdata[0], 32'd0);
      check("idle_pslverr", 32'(pslverr[0]), 32'd0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
